gen_bcd_counter: RTL and testbench
==================================

GEN_BCD_COUNTER -- requirements
Module: gen_bcd_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD decades (legal 1..8).
REQ-002 SHALL have parameter SATURATE, default 0; 0 = wrap at all-nines, 1 = hold at all-nines.
REQ-003 SHALL have parameter AUTO_SNAP, default 0; 1 = shadow copies live count every cycle, and snap is ignored.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port gen_tick, input, 1, one-cycle pulse per completed Game of Life generation.
REQ-008 SHALL have port clear, input, 1, synchronous zeroing of the live count, shadow and overflow.
REQ-009 SHALL have port hold, input, 1, level; while high, gen_tick is ignored.
REQ-010 SHALL have port snap, input, 1, one-cycle pulse that copies the live count into the display shadow.
REQ-011 SHALL have port digits, output, 4*NUM_DIGITS, shadow BCD value; digit 0 (least significant) in bits [3:0].
REQ-012 SHALL have port blank, output, NUM_DIGITS, per-digit blank request to the 7-segment character control.
REQ-013 SHALL have port overflow, output, 1, sticky flag set on wrap or saturation.

Function
REQ-014 SHALL increment the live count by exactly 1 on each clk edge where gen_tick=1, hold=0 and clear=0.
REQ-015 SHALL keep every live decade in 0..9 and propagate carry through all decades within the same cycle; there SHALL be no multi-cycle ripple.
REQ-016 SHALL, on a tick when the count is all nines with SATURATE=0, set the live count to all zeros and set overflow.
REQ-017 SHALL, on a tick when the count is all nines with SATURATE=1, leave the live count unchanged and set overflow.
REQ-018 SHALL keep overflow at 1 until clear or reset.
REQ-019 SHALL give clear priority over gen_tick, hold and snap: the next cycle has live=0, shadow=0, overflow=0.
REQ-020 SHALL load the shadow on a snap edge with the live value registered before that edge; a tick in the same cycle appears only at the next snap.
REQ-021 SHALL register digits, blank and overflow (no combinational input-to-output path).
REQ-022 SHALL give latency tick -> digits of 1 cycle with AUTO_SNAP=1, and of tick edge plus the next snap edge with AUTO_SNAP=0.
REQ-023 SHALL leave the shadow unchanged between snaps regardless of ticks (tear-free display).
REQ-024 SHALL treat gen_tick held high for N cycles as N ticks.

Reset
REQ-025 SHALL, while rst_n=0, force live=0, shadow=0, digits=0, overflow=0 and blank=0 immediately, without waiting for clk.
REQ-026 SHALL discard any tick or snap coinciding with reset deassertion edge cycle if rst_n is still low at that edge.
REQ-027 SHALL resume counting from 0 after a reset asserted mid-count; no partial carry state SHALL survive.

Configuration
REQ-028 SHALL use macro LEAD_ZERO_BLANK_EN to control leading-zero blanking.
REQ-029 SHALL, with LEAD_ZERO_BLANK_EN defined, set blank[i]=1 for each shadow digit i>0 whose value and all higher digits are 0; digit 0 SHALL never be blanked; blank is registered with digits.
REQ-030 SHALL, without LEAD_ZERO_BLANK_EN, tie blank to all zeros.

Structure
REQ-031 SHALL place in shared package gol_disp_pkg: typedef bcd_t (4-bit), constant BCD_MAX=9, constant BCD_ZERO=0.
REQ-032 SHALL implement each decade as sub-module bcd_digit_cell (inputs carry_in, clear; outputs digit, carry_out), instantiated NUM_DIGITS times.

Verification
REQ-033 SHALL verify: reset, then 12 ticks, then snap -> digits=0x0012, blank=4'b1100 (with macro), overflow=0.
REQ-034 SHALL verify: preload 9999 via 9999 ticks, SATURATE=0, one tick, snap -> digits=0x0000, overflow=1.
REQ-035 SHALL verify: same as REQ-034 with SATURATE=1 -> digits=0x9999, overflow=1.
REQ-036 SHALL verify: gen_tick, clear and snap in the same cycle at count 0x0057 -> next cycle digits=0, overflow=0.
REQ-037 SHALL verify: hold=1 with 5 ticks, then snap -> digits unchanged; ticks between snaps -> digits stable until snap.
REQ-038 SHALL verify: rst_n pulled low asynchronously mid-count at 0x0123 -> digits=0 before the next clk edge; counting restarts at 1.

Source files
------------

// File: rtl/gol_disp_pkg.sv
// Shared types and constants for the Game of Life generation display.
package gol_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: advances when carry_in is high, wraps 9 -> 0 and
// reports carry_out combinationally so a full carry settles in one cycle.
module bcd_digit_cell
  import gol_disp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic carry_in,
  output bcd_t digit,
  output logic carry_out
);

  // Carry to the next decade when this decade rolls over.
  always_comb begin
    carry_out = carry_in && (digit == BCD_MAX);
  end

  // Decade register: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_ZERO;
    end else if (clear) begin
      digit <= BCD_ZERO;
    end else if (carry_in) begin
      digit <= (digit == BCD_MAX) ? BCD_ZERO : bcd_t'(digit + 4'd1);
    end
  end

endmodule

// File: rtl/gen_bcd_counter.sv
// Multi-decade BCD generation counter with a tear-free display shadow.
// Optional macro LEAD_ZERO_BLANK_EN enables leading-zero blanking.
module gen_bcd_counter
  import gol_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned AUTO_SNAP  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gen_tick,
  input  logic                    clear,
  input  logic                    hold,
  input  logic                    snap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    overflow
);

  bcd_t                    live [NUM_DIGITS];
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] live_vec;
  logic [4*NUM_DIGITS-1:0] shadow_next;
  logic [NUM_DIGITS-1:0]   blank_next;
  logic                    all_nines;
  logic                    tick_ok;
  logic                    ovf_set;

  // Qualify the tick and detect the all-nines boundary.
  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (live[i] != BCD_MAX) all_nines = 1'b0;
    end
    tick_ok  = gen_tick && !hold && !clear;
    carry[0] = tick_ok && !((SATURATE != 0) && all_nines);
    // Wrap shows up as carry out of the top decade; saturation suppresses
    // the increment, so it is detected directly.
    ovf_set  = carry[NUM_DIGITS] || (tick_ok && all_nines && (SATURATE != 0));
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .carry_in  (carry[g]),
      .digit     (live[g]),
      .carry_out (carry[g+1])
    );
  end

  // Flatten the live decades and choose the next shadow value.
  always_comb begin
    live_vec = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      live_vec[4*i +: 4] = live[i];
    end
    shadow_next = digits;
    if (clear) begin
      shadow_next = '0;
    end else if ((AUTO_SNAP != 0) || snap) begin
      shadow_next = live_vec;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Blank each upper digit that is zero along with everything above it.
  always_comb begin
    logic higher_zero;
    blank_next  = '0;
    higher_zero = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero   = higher_zero && (shadow_next[4*i +: 4] == BCD_ZERO);
      blank_next[i] = higher_zero;
    end
  end
`else
  // Blanking disabled: every digit is always shown.
  always_comb begin
    blank_next = '0;
  end
`endif

  // Output registers: shadow digits, blank mask and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits   <= '0;
      blank    <= '0;
      overflow <= 1'b0;
    end else begin
      digits   <= shadow_next;
      blank    <= blank_next;
      overflow <= clear ? 1'b0 : (overflow || ovf_set);
    end
  end

endmodule

// File: tb/tb_gen_bcd_counter.sv
// Bench for gen_bcd_counter: a wrapping and a saturating instance share
// stimulus; an integer model predicts both and is checked every cycle.
module tb_gen_bcd_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_tick = 1'b0;
  logic        clear = 1'b0;
  logic        hold = 1'b0;
  logic        snap = 1'b0;
  logic [15:0] dig0, dig1;
  logic [3:0]  blk0, blk1;
  logic        ovf0, ovf1;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Behavioural model: plain integers, index 0 wraps, index 1 saturates.
  int m_live [2];
  int m_shadow [2];
  bit m_ovf [2];

  always #5 clk = ~clk;

  gen_bcd_counter #(.NUM_DIGITS(4), .SATURATE(0), .AUTO_SNAP(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .gen_tick(gen_tick), .clear(clear),
    .hold(hold), .snap(snap), .digits(dig0), .blank(blk0), .overflow(ovf0)
  );

  gen_bcd_counter #(.NUM_DIGITS(4), .SATURATE(1), .AUTO_SNAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .gen_tick(gen_tick), .clear(clear),
    .hold(hold), .snap(snap), .digits(dig1), .blank(blk1), .overflow(ovf1)
  );

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_blank(int v);
    logic [3:0] b;
    int         p;
    b = '0;
`ifdef LEAD_ZERO_BLANK_EN
    p = 10;
    for (int i = 1; i < 4; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
`else
    p = v;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model update from the counting rules.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || clear) begin
        m_live[k] = 0; m_shadow[k] = 0; m_ovf[k] = 1'b0;
      end else begin
        if (snap) m_shadow[k] = m_live[k];
        if (gen_tick && !hold) begin
          if (m_live[k] == 9999) begin
            m_ovf[k] = 1'b1;
            if (k == 0) m_live[k] = 0;
          end else begin
            m_live[k] = m_live[k] + 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("wrap_digits", 32'(dig0), 32'(to_bcd(m_shadow[0])));
    chk("wrap_blank", 32'(blk0), 32'(exp_blank(m_shadow[0])));
    chk("wrap_ovf", 32'(ovf0), 32'(m_ovf[0]));
    chk("sat_digits", 32'(dig1), 32'(to_bcd(m_shadow[1])));
    chk("sat_blank", 32'(blk1), 32'(exp_blank(m_shadow[1])));
    chk("sat_ovf", 32'(ovf1), 32'(m_ovf[1]));
  end

  task automatic step(input logic t, input logic c, input logic h, input logic s);
    gen_tick = t; clear = c; hold = h; snap = s;
    @(posedge clk); #1;
    gen_tick = 1'b0; clear = 1'b0; hold = 1'b0; snap = 1'b0;
  endtask

  task automatic ticks(input int n);
    gen_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 gen_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b12;
    b12 = 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
    b12 = 4'b1100;
`endif
    // Reset, with a tick and snap present at an edge while still in reset.
    gen_tick = 1'b1; snap = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", 32'(dig0), 32'h0);
    chk("reset_ovf", 32'(ovf0), 32'h0);
    gen_tick = 1'b0; snap = 1'b0;
    rst_n = 1'b1;

    // 12 ticks then snap.
    ticks(12);
    step(0, 0, 0, 1);
    chk("t12_digits", 32'(dig0), 32'h0012);
    chk("t12_blank", 32'(blk0), 32'(b12));
    chk("t12_ovf", 32'(ovf0), 32'h0);

    // Hold masks ticks; ticks without snap leave the display alone.
    hold = 1'b1;
    ticks(5);
    hold = 1'b0;
    step(0, 0, 0, 1);
    chk("hold_digits", 32'(dig0), 32'h0012);
    ticks(3);
    chk("stable_digits", 32'(dig0), 32'h0012);
    step(0, 0, 0, 1);
    chk("after_snap", 32'(dig0), 32'h0015);

    // Tick coinciding with snap: snap sees the pre-edge count.
    step(1, 0, 0, 1);
    chk("tick_snap_same", 32'(dig0), 32'h0015);
    step(0, 0, 0, 1);
    chk("tick_snap_next", 32'(dig0), 32'h0016);

    // Preload all nines, then one more tick.
    step(0, 1, 0, 0);
    ticks(9999);
    step(0, 0, 0, 1);
    chk("nines_wrap", 32'(dig0), 32'h9999);
    chk("nines_sat", 32'(dig1), 32'h9999);
    chk("nines_ovf", 32'(ovf0), 32'h0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("wrap_digits_lit", 32'(dig0), 32'h0000);
    chk("wrap_ovf_lit", 32'(ovf0), 32'h1);
    chk("sat_digits_lit", 32'(dig1), 32'h9999);
    chk("sat_ovf_lit", 32'(ovf1), 32'h1);
    ticks(4);
    chk("ovf_sticky", 32'(ovf0), 32'h1);

    // Clear beats tick and snap in the same cycle.
    step(0, 1, 0, 0);
    ticks(57);
    step(0, 0, 0, 1);
    chk("c57_digits", 32'(dig0), 32'h0057);
    step(1, 1, 0, 1);
    chk("clr_digits", 32'(dig0), 32'h0000);
    chk("clr_ovf", 32'(ovf1), 32'h0);

    // Asynchronous reset mid-count at 123.
    ticks(123);
    step(0, 0, 0, 1);
    chk("c123_digits", 32'(dig0), 32'h0123);
    #3 rst_n = 1'b0;
    #1;
    chk("async_digits", 32'(dig0), 32'h0000);
    chk("async_sat_digits", 32'(dig1), 32'h0000);
    chk("async_blank", 32'(blk0), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("restart_digits", 32'(dig0), 32'h0001);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
